// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Round-robin arbiter that grants one core at a time and
//               sequences a single access to a shared synchronous data RAM,
//               returning read data and a one-cycle done pulse to the owner.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int NCORES  = 4,
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int MEM_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCORES-1:0]    req,
    input  logic [NCORES-1:0]    we,
    input  logic [NCORES*AW-1:0] addr,
    input  logic [NCORES*DW-1:0] wdata,
    output logic [NCORES-1:0]    gnt,
    output logic [NCORES-1:0]    done,
    output logic [DW-1:0]        rdata,
    output logic                 busy,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata
);

    // Index width for core numbers and counter width for the WAIT countdown
    localparam int IW = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(NCORES - 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   last_q,  last_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [IW-1:0]   idx_q,   idx_d;
    logic            we_q,    we_d;
    logic [AW-1:0]   addr_q,  addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;

    // Round-robin search results
    logic [IW-1:0]   rr_cand;
    logic            rr_found;
    logic [IW-1:0]   rr_win;

    // Round-robin search: start one past the last winner, wrap at NCORES-1
    always_comb begin
        rr_found = 1'b0;
        rr_win   = '0;
        rr_cand  = (last_q == LAST_IDX) ? '0 : last_q + 1'b1;
        for (int k = 0; k < NCORES; k++) begin
            if (!rr_found && req[rr_cand]) begin
                rr_found = 1'b1;
                rr_win   = rr_cand;
            end
            rr_cand = (rr_cand == LAST_IDX) ? '0 : rr_cand + 1'b1;
        end
    end

    // Next-state and latched-transaction logic
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                // Requests are only looked at here; later changes are ignored
                if (rr_found) begin
                    idx_d   = rr_win;
                    we_d    = we[rr_win];
                    addr_d  = addr[rr_win*AW +: AW];
                    wdata_d = wdata[rr_win*DW +: DW];
                    last_d  = rr_win;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                cnt_d   = CNT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // The last WAIT cycle is the one in which RAM read data is valid
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and transaction registers; reset abandons any transaction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            last_q  <= LAST_IDX;
            cnt_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Per-core owner and completion indications
    for (genvar i = 0; i < NCORES; i++) begin : g_core
        assign gnt[i]  = (state_q != S_IDLE) && (idx_q == IW'(i));
        assign done[i] = (state_q == S_DONE) && (idx_q == IW'(i));
    end

    // RAM side: address/data/we simply hold the latched values, mem_en qualifies
    assign mem_en    = (state_q == S_ACCESS);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign rdata = rdata_q;
    assign busy  = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shared data-memory arbiter for the multicore processor. Each core's register file drives its own data-memory request (address from AR, write data from DR, read/write intent). This block grants one core at a time in round-robin order and sequences a single access to the shared synchronous data RAM. It then returns read data and a one-cycle completion pulse to the owning core. It sits between the N core datapaths and the single data memory port.

## Interface
Parameters:
- NCORES, 4, number of requesting cores (2..8)
- AW, 16, address width
- DW, 16, data width
- MEM_LAT, 1, RAM read latency in cycles after the access cycle (1..4)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- req  in  NCORES  per-core request level
- we  in  NCORES  per-core write enable: 1 = write, 0 = read
- addr  in  NCORES*AW  per-core address; core i occupies bits [i*AW +: AW]
- wdata  in  NCORES*DW  per-core write data, packed the same way as addr
- gnt  out  NCORES  one-hot owner indication
- done  out  NCORES  one-cycle completion pulse to the owner
- rdata  out  DW  read data, shared by all cores, valid while done is high
- busy  out  1  high when the arbiter is in any state other than IDLE
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data

## Operation
FSM states:
- **IDLE**
  - If no req is high, stay in IDLE.
  - Otherwise select the winner by round-robin. The search starts at (last+1) mod NCORES and takes the first index with req high.
  - Latch the winner's idx, we, addr and wdata. Set last = idx. Go to ACCESS.
- **ACCESS** (1 cycle)
  - mem_en=1, mem_we=we_q, mem_addr=addr_q, mem_wdata=wdata_q.
  - Load cnt=MEM_LAT-1. Go to WAIT.
- **WAIT** (MEM_LAT cycles)
  - mem_en=0.
  - If cnt==0: for a read, capture mem_rdata into rdata_q (writes leave rdata_q unchanged), then go to DONE.
  - Otherwise decrement cnt.
- **DONE** (1 cycle)
  - done[idx]=1; rdata drives rdata_q. Go to IDLE.

Output rules:
- gnt[idx]=1 in ACCESS, WAIT and DONE; all other gnt bits are 0.
- busy = (state != IDLE).
- mem_addr, mem_wdata and mem_we hold their latched values outside ACCESS; only mem_en qualifies an access.
- Request inputs are sampled only in IDLE. Changes to req, we, addr or wdata during ACCESS, WAIT or DONE have no effect.

Core-side protocol:
- A core holds req, we, addr and wdata stable until its done pulse.
- The core deasserts req in the cycle after done unless it has a new request.
- If the owner drops req mid-transaction, that is a protocol violation. The latched transaction still completes and done still pulses.

Round-robin pointer:
- last resets to NCORES-1, so core 0 has first priority after reset.
- A core with req held continuously is granted at least once every NCORES transactions.

## Timing
Reset values (asynchronous, effective immediately on rst high):
- state=IDLE, last=NCORES-1, cnt=0, rdata_q=0, latched idx/we/addr/wdata=0.
- Outputs: gnt=0, done=0, rdata=0, busy=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.

Latency and throughput:
- A req seen high in IDLE at edge 0 gives ACCESS in cycle 1, WAIT in cycles 2..MEM_LAT+1, DONE in cycle MEM_LAT+2.
- Each transaction occupies MEM_LAT+3 cycles including the IDLE arbitration cycle.
- The minimum back-to-back issue period is MEM_LAT+3 cycles.

mem_rdata sampling:
- mem_rdata is valid in the cycle MEM_LAT cycles after ACCESS. It is sampled on the rising edge that ends that cycle, which is the last WAIT cycle.

Boundary conditions:
- Simultaneous requests: exactly one winner per IDLE cycle, chosen by the round-robin rule; the others wait with req held.
- Pointer wrap-around: last=NCORES-1 searches from index 0.
- A lone requester is granted regardless of the pointer position.
- Reset mid-transaction: the transaction is abandoned. done never pulses, mem_en drops immediately, and the core must reissue the request after reset.

## Test plan
- **Single read:** reset, RAM[0x0040]=0xBEEF, core 2 raises req, we=0, addr=0x0040 -> mem_en for exactly 1 cycle with mem_addr=0x0040; done[2] in cycle 3 after req (MEM_LAT=1) with rdata=0xBEEF; gnt=4'b0100 during ACCESS/WAIT/DONE.
- **Single write:** core 1 writes 0x1234 to 0x0010 -> mem_en=1, mem_we=1, mem_wdata=0x1234 for one cycle; done[1] pulses; rdata unchanged; a subsequent read of 0x0010 by core 3 returns 0x1234.
- **Four-way contention:** all four cores request from reset and hold req until their done -> grant order 0,1,2,3; done pulses spaced 4 cycles apart (MEM_LAT=1).
- **Fairness and wrap:** cores 3 and 0 request continuously, re-raising req after each done -> grants alternate 0,3,0,3; no core is starved over 20 transactions.
- **Reset mid-operation:** assert rst during WAIT of a core 1 read -> busy, gnt and mem_en go to 0 immediately; no done pulse; after release, core 1 reissues and is served normally.
- **MEM_LAT=3:** core 0 reads 0x00FF holding 0xA5A5 -> 3 WAIT cycles; done[0] in cycle 5 after req; rdata=0xA5A5; cnt sequence observed as 2,1,0.
